// File: rtl/sram_cmd_sequencer.sv
// sram_cmd_sequencer: valid/ready command front-end that serialises write words and
// strobes reads for sram_top. Define SRAM_SEQ_TIMEOUT_EN to bound the read wait.
module sram_cmd_sequencer #(
   parameter int ROWS       = 16,
   parameter int COLS       = 8,
   parameter int SHIFT_CYC  = 2,
   parameter int RD_TIMEOUT = 16,
   localparam int AW        = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [COLS-1:0] cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [COLS-1:0] rsp_data,
   output logic            rsp_err,
   output logic            wr_done,
   output logic            serial_in,
   output logic            shift,
   output logic            w_en,
   output logic            r_en,
   output logic [AW-1:0]   addr,
   input  logic            data_valid,
   input  logic [COLS-1:0] data_out
);

   localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int HW = (SHIFT_CYC > 1) ? $clog2(SHIFT_CYC) : 1;
   localparam logic [BW-1:0] BIT_MSB   = BW'(COLS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(SHIFT_CYC - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SHIFT  = 3'd1;
   localparam logic [2:0] S_WGAP   = 3'd2;
   localparam logic [2:0] S_WPULSE = 3'd3;
   localparam logic [2:0] S_RGAP   = 3'd4;
   localparam logic [2:0] S_RPULSE = 3'd5;
   localparam logic [2:0] S_RWAIT  = 3'd6;
   localparam logic [2:0] S_RESP   = 3'd7;

   if (SHIFT_CYC < 1 || RD_TIMEOUT < 1 || COLS < 2 || ROWS < 2) begin : g_bad_params
      $error("sram_cmd_sequencer: SHIFT_CYC/RD_TIMEOUT must be >=1, COLS/ROWS >=2");
   end

   logic [2:0]      r_state;
   logic [AW-1:0]   r_addr;
   logic [COLS-1:0] r_wdata;
   logic [BW-1:0]   r_bit;
   logic [HW-1:0]   r_hold;
   logic [COLS-1:0] r_rsp_data;
   logic            w_idle;
   logic            w_shift;

`ifdef SRAM_SEQ_TIMEOUT_EN
   localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
   logic [TW-1:0] r_tmo;
   logic          r_rsp_err;
`endif

   // NOTE: all state below uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_bit      <= '0;
         r_hold     <= '0;
         r_rsp_data <= '0;
`ifdef SRAM_SEQ_TIMEOUT_EN
         r_tmo      <= '0;
         r_rsp_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_bit   <= BIT_MSB;
                  r_hold  <= '0;
                  r_state <= cmd_we ? S_SHIFT : S_RGAP;
               end
            end
            // Each bit is held SHIFT_CYC clocks; bit 0 finishing ends the word.
            S_SHIFT: begin
               if (r_hold == HOLD_LAST) begin
                  r_hold <= '0;
                  if (r_bit == '0) r_state <= S_WGAP;
                  else             r_bit   <= r_bit - BW'(1);
               end else begin
                  r_hold <= r_hold + HW'(1);
               end
            end
            S_WGAP:   r_state <= S_WPULSE;
            S_WPULSE: r_state <= S_IDLE;
            S_RGAP:   r_state <= S_RPULSE;
            S_RPULSE, S_RWAIT: begin
               if (data_valid) begin
                  r_rsp_data <= data_out;
                  r_state    <= S_RESP;
`ifdef SRAM_SEQ_TIMEOUT_EN
                  r_rsp_err  <= 1'b0;
`endif
               end else if (r_state == S_RPULSE) begin
                  r_state <= S_RWAIT;
`ifdef SRAM_SEQ_TIMEOUT_EN
                  r_tmo   <= '0;
               end else if (r_tmo == TMO_LAST) begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
`endif
               end
            end
            S_RESP: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode straight from the state so they can never overlap.
   assign w_idle    = (r_state == S_IDLE);
   assign w_shift   = (r_state == S_SHIFT);
   assign cmd_ready = w_idle & ~rst;
   assign shift     = w_shift;
   assign serial_in = w_shift & r_wdata[r_bit];
   assign w_en      = (r_state == S_WPULSE);
   assign wr_done   = (r_state == S_WPULSE);
   assign r_en      = (r_state == S_RPULSE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_data  = r_rsp_data;
   assign addr      = r_addr;

`ifdef SRAM_SEQ_TIMEOUT_EN
   assign rsp_err = r_rsp_err;
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Bench for sram_cmd_sequencer: directed commands, a small sram_top stand-in and a
// cycle-level model that predicts every output from the command timing rules.
module tb_sram_cmd_sequencer;

   localparam int ROWS = 16, COLS = 8, SC = 2, RD_TIMEOUT = 16, AW = 4;
   localparam int NSH  = COLS * SC;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0]   cmd_addr, addr;
   logic [COLS-1:0] cmd_wdata, rsp_data, data_out;
   logic            rsp_valid, rsp_ready, rsp_err, wr_done;
   logic            serial_in, shift, w_en, r_en, data_valid;

   always #5 clk = ~clk;

   sram_cmd_sequencer #(.ROWS(ROWS), .COLS(COLS), .SHIFT_CYC(SC), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .wr_done(wr_done), .serial_in(serial_in),
      .shift(shift), .w_en(w_en), .r_en(r_en), .addr(addr), .data_valid(data_valid),
      .data_out(data_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // sram_top stand-in: assembles the serial word, stores on w_en, answers r_en 2 cycles later.
   logic [COLS-1:0] mem [ROWS];
   logic [COLS-1:0] s_reg, rd_word;
   logic [1:0]      rd_pipe;
   int              s_cnt;
   logic            mute = 1'b0, stray = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         rd_pipe <= '0;
         s_cnt   <= 0;
      end else begin
         rd_pipe <= {rd_pipe[0], r_en};
         if (r_en) rd_word <= mem[addr];
         if (shift) begin
            if (s_cnt % SC == SC - 1) s_reg <= {s_reg[COLS-2:0], serial_in};
            s_cnt <= s_cnt + 1;
         end else begin
            s_cnt <= 0;
         end
         if (w_en) mem[addr] <= s_reg;
      end
   end

   assign data_valid = (rd_pipe[1] & ~mute) | stray;
   assign data_out   = stray ? 8'hFF : rd_word;

   // Model: k counts cycles since the accepting edge; outputs follow from k and the command.
   bit              m_on = 1'b0, m_busy = 1'b0, m_we = 1'b0, m_resp = 1'b0, m_rsp_err = 1'b0;
   int              m_k = 0;
   logic [AW-1:0]   m_addr;
   logic [COLS-1:0] m_wdata, m_rsp_data;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b0; m_resp = 1'b0; m_rsp_data = '0; m_rsp_err = 1'b0;
      end else if (m_on) begin
         if (!m_busy) begin
            if (cmd_valid) begin
               m_busy = 1'b1; m_we = cmd_we; m_addr = cmd_addr; m_wdata = cmd_wdata; m_k = 1;
            end
         end else if (m_we) begin
            if (m_k == NSH + 2) m_busy = 1'b0;
            else m_k++;
         end else if (m_resp) begin
            if (rsp_ready) begin m_busy = 1'b0; m_resp = 1'b0; end
         end else if (m_k >= 2 && data_valid) begin
            m_resp = 1'b1; m_rsp_data = data_out; m_rsp_err = 1'b0;
`ifdef SRAM_SEQ_TIMEOUT_EN
         end else if (m_k == 2 + RD_TIMEOUT) begin
            m_resp = 1'b1; m_rsp_data = '0; m_rsp_err = 1'b1;
`endif
         end else begin
            m_k++;
         end
      end
   end

   logic e_sh, e_si;
   always @(negedge clk) begin
      if (m_on) begin
         e_sh = m_busy && m_we && m_k <= NSH;
         e_si = e_sh ? m_wdata[COLS - 1 - (m_k - 1) / SC] : 1'b0;
         check("cmd_ready", cmd_ready, !rst && !m_busy);
         check("shift", shift, e_sh);
         check("serial_in", serial_in, e_si);
         check("w_en", w_en, m_busy && m_we && m_k == NSH + 2);
         check("wr_done", wr_done, m_busy && m_we && m_k == NSH + 2);
         check("r_en", r_en, m_busy && !m_we && !m_resp && m_k == 2);
         check("rsp_valid", rsp_valid, m_resp);
         check("rsp_data", rsp_data, m_rsp_data);
         check("rsp_err", rsp_err, m_rsp_err);
         if (m_busy) check("addr", addr, m_addr);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 64) begin tick(); n++; end
      if (!cmd_ready) check("ready_wait_expired", 0, 1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (n) begin
         tick();
         check("rst_cmd_ready", cmd_ready, 0);
         check("rst_outputs", {shift, serial_in, w_en, r_en, rsp_valid, wr_done, rsp_err, rsp_data, addr}, 0);
      end
      rst = 1'b0;
      tick();
      check("post_rst_ready", cmd_ready, 1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [COLS-1:0] d,
                           output logic [15:0] bits, output int ns);
      int cyc;
      wait_ready();
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d;
      tick();
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = ~a; cmd_wdata = ~d;
      cyc = 1; bits = '0; ns = 0;
      while (!w_en && cyc < 64) begin
         if (shift) begin bits = {bits[14:0], serial_in}; ns++; end
         tick();
         cyc++;
      end
      check("wr_latency", cyc, NSH + 2);
      check("wr_addr", addr, a);
      tick();
      check("wr_next_ready", cmd_ready, 1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold, input logic [COLS-1:0] exp_d,
                          input logic exp_e, input int exp_lat);
      int cyc;
      wait_ready();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_wdata = '1;
      tick();
      cmd_valid = 1'b0; cmd_we = 1'b1; cmd_addr = ~a;
      cyc = 1;
      while (!rsp_valid && cyc < 64) begin tick(); cyc++; end
      check("rd_latency", cyc, exp_lat);
      check("rd_data", rsp_data, exp_d);
      check("rd_err", rsp_err, exp_e);
      repeat (hold) begin
         tick();
         check("hold_valid", rsp_valid, 1);
         check("hold_data", rsp_data, exp_d);
         check("hold_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rd_released", rsp_valid, 0);
      check("rd_next_ready", cmd_ready, 1);
   endtask

   initial begin
      logic [15:0]     bits;
      int              ns, seen;
      logic [AW-1:0]   a;
      logic [COLS-1:0] d;
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;

      do_reset(3);

      // 8'hA5 with every bit doubled, MSB first.
      do_write(4'd3, 8'hA5, bits, ns);
      check("a5_serial", bits, 16'hCC33);
      check("a5_shift_cycles", ns, 16);
      check("a5_stored", s_reg, 8'hA5);

      do_write(4'd5, 8'h3C, bits, ns);
      do_read(4'd5, 4, 8'h3C, 1'b0, 5);

      for (int i = 0; i < ROWS; i++) begin
         a = AW'(i);
         d = COLS'($urandom_range(0, 255));
         do_write(a, d, bits, ns);
         do_read(a, i % 3, d, 1'b0, 5);
      end

      // Stray data_valid while idle must not produce a response.
      stray = 1'b1;
      repeat (3) begin tick(); check("stray_no_rsp", rsp_valid, 0); end
      stray = 1'b0;

      // Reset while bit 4 is on the serial line drops the write.
      wait_ready();
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd7; cmd_wdata = 8'hF0;
      tick();
      cmd_valid = 1'b0;
      repeat (6) tick();
      check("mid_shift_active", shift, 1);
      check("mid_shift_bit4", serial_in, 1);
      rst = 1'b1;
      repeat (2) begin
         tick();
         check("mid_rst_quiet", {shift, serial_in, w_en, r_en, rsp_valid, wr_done}, 0);
      end
      rst = 1'b0;
      seen = 0;
      repeat (24) begin tick(); if (w_en || rsp_valid || shift) seen++; end
      check("dropped_cmd_quiet", seen, 0);

      do_write(4'd7, 8'h5A, bits, ns);
      check("after_rst_serial", bits, 16'h33CC);
      do_read(4'd7, 1, 8'h5A, 1'b0, 5);

`ifdef SRAM_SEQ_TIMEOUT_EN
      mute = 1'b1;
      do_read(4'd9, 2, 8'h00, 1'b1, 3 + RD_TIMEOUT);
      mute = 1'b0;
      do_read(4'd7, 0, 8'h5A, 1'b0, 5);
`endif

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
